compress42_acc_pipe: RTL and testbench

COMPRESS42_ACC_PIPE -- requirements
Module: compress42_acc_pipe

---
 rtl/compress42_acc_pipe.sv | 101 ++++++++++
 tb/tb_compress42_acc_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/compress42_acc_pipe.sv
// Two-stage adder of four unsigned operands with optional running accumulation.
// Stage 1 is a carry-save row of 4:2 compressors; stage 2 does the single carry-propagate add.
module compress42_acc_pipe #(
  parameter int WIDTH = 16,
  parameter int ACC_W = WIDTH + 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             acc_mode,
  input  logic             acc_clr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  // cin_w[i] is the cin of cell i; cin_w[WIDTH] is the cout leaving the top cell.
  logic [WIDTH:0]   cin_w;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] carry_w;

  assign cin_w[0] = 1'b0;

  // Each cell: full adder on (a,b,c) then full adder on (partial, d, cin).
  // cout depends only on a,b,c, so the cin chain never ripples.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic part_w;
      assign part_w       = a[gi] ^ b[gi] ^ c[gi];
      assign cin_w[gi+1]  = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
      assign sum_w[gi]    = part_w ^ d[gi] ^ cin_w[gi];
      assign carry_w[gi]  = (part_w & d[gi]) | (part_w & cin_w[gi]) | (d[gi] & cin_w[gi]);
    end
  endgenerate

  logic [WIDTH:0] s_reg;
  logic [WIDTH:0] c_reg;
  logic           s1_valid_reg;
  logic           mode_reg;
  logic           clr_reg;

  logic             accept;
  logic             stage2_load;
  logic [ACC_W-1:0] prev_w;
  logic [ACC_W:0]   total_w;

  assign stage2_load = s1_valid_reg && (!out_valid || out_ready);
  assign in_ready    = !s1_valid_reg || stage2_load;
  assign accept      = in_valid && in_ready;

  assign prev_w  = (mode_reg && !clr_reg) ? out_sum : '0;
  // One extra bit above ACC_W captures the wrap-around as the overflow flag.
  assign total_w = {{(ACC_W-WIDTH){1'b0}}, s_reg}
                 + {{(ACC_W-WIDTH){1'b0}}, c_reg}
                 + {1'b0, prev_w};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg        <= '0;
      c_reg        <= '0;
      mode_reg     <= 1'b0;
      clr_reg      <= 1'b0;
      s1_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        s_reg    <= {cin_w[WIDTH], sum_w};
        c_reg    <= {carry_w, 1'b0};
        mode_reg <= acc_mode;
        clr_reg  <= acc_clr;
      end
      if (accept) begin
        s1_valid_reg <= 1'b1;
      end else if (stage2_load) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (stage2_load) begin
        out_sum   <= total_w[ACC_W-1:0];
        out_ovf   <= total_w[ACC_W];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_compress42_acc_pipe.sv
// Bench for compress42_acc_pipe: vector table, backpressure, mid-run reset and random traffic,
// all checked through an in-order scoreboard of expected results.
module tb_compress42_acc_pipe;
  localparam int WIDTH = 8;
  localparam int ACC_W = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic             acc_mode = 1'b0, acc_clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  compress42_acc_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a(in_a), .b(in_b), .c(in_c), .d(in_d),
    .acc_mode(acc_mode), .acc_clr(acc_clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [7:0]       a, b, c, d;
    logic             m, cl;
    logic [ACC_W-1:0] s;
    logic             o;
  } vec_t;

  exp_t             expq[$];
  vec_t             tab[10];
  int               n_checks = 0;
  int               n_errors = 0;
  int               n_out = 0;
  logic [ACC_W-1:0] model_prev = '0;
  logic             acc_flag = 1'b0;
  logic             use_tab = 1'b0;
  logic [ACC_W-1:0] tab_sum = '0;
  logic             tab_ovf = 1'b0;
  logic             rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  // One clock: sample handshakes 1 time unit before the rising edge, then move to the next falling edge.
  task automatic cycle();
    logic [31:0] full;
    exp_t        e;
    #4;
    acc_flag = 1'b0;
    if (in_valid && in_ready) begin
      acc_flag = 1'b1;
      full = 32'(in_a) + 32'(in_b) + 32'(in_c) + 32'(in_d)
           + ((acc_mode && !acc_clr) ? 32'(model_prev) : 32'd0);
      e.sum = full[ACC_W-1:0];
      e.ovf = (full >= (32'd1 << ACC_W));
      if (use_tab) begin
        e.sum = tab_sum;
        e.ovf = tab_ovf;
      end
      model_prev = e.sum;
      expq.push_back(e);
      $display("accept a=%h b=%h c=%h d=%h mode=%0d clr=%0d exp=%h ovf=%0d",
               in_a, in_b, in_c, in_d, acc_mode, acc_clr, e.sum, e.ovf);
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (expq.size() == 0) begin
        chk("spurious_output", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("out_sum", 32'(out_sum), 32'(e.sum));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
    @(negedge clk);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] va, vb, vc, vd, input logic m, cl, output int waited);
    in_a = va; in_b = vb; in_c = vc; in_d = vd;
    acc_mode = m; acc_clr = cl; in_valid = 1'b1;
    waited = 0;
    acc_flag = 1'b0;
    while (!acc_flag && waited < 50) begin
      cycle();
      if (!acc_flag) waited++;
    end
    if (!acc_flag) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 30 && expq.size() > 0; t++) cycle();
    chk(name, 32'(expq.size()), 32'd0);
  endtask

  logic [7:0] bp_v[4];
  int         w;
  int         k;
  int         n0;

  initial begin
    tab[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 10'h3FC, 1'b0};
    tab[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b1, 10'h00A, 1'b0};
    tab[2] = '{8'h05, 8'h06, 8'h07, 8'h08, 1'b1, 1'b0, 10'h024, 1'b0};
    tab[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 10'h3FC, 1'b0};
    tab[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 10'h3F8, 1'b1};
    tab[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 10'h3F8, 1'b0};
    tab[6] = '{8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 1'b0, 10'h0A0, 1'b0};
    tab[7] = '{8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 10'h0A1, 1'b0};
    tab[8] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 1'b1, 10'h200, 1'b0};
    tab[9] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 10'h1FE, 1'b0};

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: result visible after the second edge counting the accept edge
    use_tab = 1'b1;
    tab_sum = tab[0].s; tab_ovf = tab[0].o;
    send(tab[0].a, tab[0].b, tab[0].c, tab[0].d, tab[0].m, tab[0].cl, w);
    chk("first_accept_wait", 32'(w), 32'd0);
    chk("lat_valid_early", 32'(out_valid), 32'd0);
    cycle();
    chk("lat_valid_on_time", 32'(out_valid), 32'd1);
    drain("lat_drain");
    cycle();

    // Table vectors back-to-back: one accept per cycle
    for (int i = 1; i < 10; i++) begin
      tab_sum = tab[i].s; tab_ovf = tab[i].o;
      send(tab[i].a, tab[i].b, tab[i].c, tab[i].d, tab[i].m, tab[i].cl, w);
      chk("tab_throughput", 32'(w), 32'd0);
    end
    use_tab = 1'b0;
    drain("tab_drain");

    // Inputs with in_valid low are ignored
    in_a = 8'hFF; in_b = 8'hFF; in_c = 8'hFF; in_d = 8'hFF;
    acc_mode = 1'b1; acc_clr = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("idle_no_output", 32'(out_valid), 32'd0);
    send(8'h02, 8'h02, 8'h02, 8'h02, 1'b1, 1'b0, w);
    drain("idle_drain");

    // Backpressure: only two beats fit while the output is stalled
    bp_v[0] = 8'h11; bp_v[1] = 8'h22; bp_v[2] = 8'h33; bp_v[3] = 8'h44;
    out_ready = 1'b0;
    k = 0;
    n0 = n_out;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (k < 4) begin
        in_a = bp_v[k]; in_b = bp_v[k] + 8'd1; in_c = 8'(k); in_d = 8'h05;
        acc_mode = 1'b1; acc_clr = (k == 0);
      end
      in_valid = 1'b1;
      cycle();
      if (acc_flag) k++;
    end
    chk("bp_accepted", 32'(k), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    if (expq.size() != 0) chk("bp_hold_sum", 32'(out_sum), 32'(expq[0].sum));
    else chk("bp_hold_missing", 32'd0, 32'd1);
    out_ready = 1'b1;
    for (int t = 0; t < 20 && k < 4; t++) begin
      in_a = bp_v[k]; in_b = bp_v[k] + 8'd1; in_c = 8'(k); in_d = 8'h05;
      acc_mode = 1'b1; acc_clr = 1'b0;
      in_valid = 1'b1;
      cycle();
      if (acc_flag) k++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 32'(k), 32'd4);
    drain("bp_drain");
    chk("bp_out_count", 32'(n_out - n0), 32'd4);

    // Reset with both stages full
    out_ready = 1'b0;
    send(8'h30, 8'h31, 8'h32, 8'h33, 1'b0, 1'b0, w);
    send(8'h40, 8'h41, 8'h42, 8'h43, 1'b1, 1'b0, w);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
    chk("mid_rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    expq.delete();
    model_prev = '0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    use_tab = 1'b1;
    tab_sum = 10'h004; tab_ovf = 1'b0;
    send(8'h01, 8'h01, 8'h01, 8'h01, 1'b1, 1'b0, w);
    chk("post_rst_accept_wait", 32'(w), 32'd0);
    use_tab = 1'b0;
    drain("post_rst_drain");

    // Random traffic with random output backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        cycle();
      end
      send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), w);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
